// File: rtl/relm_mul_pipe_pkg.sv
// Shared constants for the relm_mul_pipe multiplier slice.
// Build option RELM_MUL_SIGNED_EN (see relm_mul_pipe.sv) adds signed multiply.
package relm_mul_pipe_pkg;

  localparam int unsigned RELM_WD = 32;

  // Half-word width used for the partial products; operand width must be even.
  function automatic int unsigned relm_wh(int unsigned wd);
    return wd / 2;
  endfunction

endpackage

// File: rtl/relm_mul_pipe_if.sv
// Operand/result bundle between the ALU extension and relm_mul_pipe.
// signed_in exists only when RELM_MUL_SIGNED_EN is defined.
interface relm_mul_pipe_if
  import relm_mul_pipe_pkg::*;
#(
  parameter int unsigned WD = RELM_WD
) ();

  logic            en_in;
  logic            flush_in;
  logic            valid_in;
  logic [WD-1:0]   a_in;
  logic [WD-1:0]   x_in;
`ifdef RELM_MUL_SIGNED_EN
  logic            signed_in;
`endif
  logic [2*WD-1:0] ax_out;
  logic            valid_out;
  logic            busy_out;

`ifdef RELM_MUL_SIGNED_EN
  modport master (
    output en_in, flush_in, valid_in, a_in, x_in, signed_in,
    input  ax_out, valid_out, busy_out
  );
  modport slave (
    input  en_in, flush_in, valid_in, a_in, x_in, signed_in,
    output ax_out, valid_out, busy_out
  );
`else
  modport master (
    output en_in, flush_in, valid_in, a_in, x_in,
    input  ax_out, valid_out, busy_out
  );
  modport slave (
    input  en_in, flush_in, valid_in, a_in, x_in,
    output ax_out, valid_out, busy_out
  );
`endif

endinterface

// File: rtl/relm_mul_half.sv
// Registered WH x WH unsigned multiplier with load enable and async reset.
module relm_mul_half
  import relm_mul_pipe_pkg::*;
#(
  parameter int unsigned WH = relm_wh(RELM_WD)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            load,
  input  logic [WH-1:0]   a,
  input  logic [WH-1:0]   b,
  output logic [2*WH-1:0] p
);

  logic [2*WH-1:0] a_ext;
  logic [2*WH-1:0] b_ext;

  always_comb begin
    a_ext = {{WH{1'b0}}, a};
    b_ext = {{WH{1'b0}}, b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (en && load) begin
      p <= a_ext * b_ext;
    end
  end

endmodule

// File: rtl/relm_mul_pipe.sv
// Two-stage WD x WD -> 2*WD multiplier feeding the ALU's mul_ax input.
// Define RELM_MUL_SIGNED_EN to add signed_in and two's-complement correction.
module relm_mul_pipe
  import relm_mul_pipe_pkg::*;
#(
  parameter int unsigned WD = RELM_WD
) (
  input  logic            clk,
  input  logic            rst_n,
  relm_mul_pipe_if.slave  bus
);

  localparam int unsigned WH = relm_wh(WD);

  logic [WD-1:0]   pp_ll, pp_lh, pp_hl, pp_hh;
  logic            v1_q, v2_q;
  logic [2*WD-1:0] ax_q;
  logic [2*WD-1:0] sum;

  relm_mul_half #(.WH(WH)) u_ll (
    .clk(clk), .rst_n(rst_n), .en(bus.en_in), .load(bus.valid_in),
    .a(bus.a_in[WH-1:0]), .b(bus.x_in[WH-1:0]), .p(pp_ll)
  );
  relm_mul_half #(.WH(WH)) u_lh (
    .clk(clk), .rst_n(rst_n), .en(bus.en_in), .load(bus.valid_in),
    .a(bus.a_in[WH-1:0]), .b(bus.x_in[WD-1:WH]), .p(pp_lh)
  );
  relm_mul_half #(.WH(WH)) u_hl (
    .clk(clk), .rst_n(rst_n), .en(bus.en_in), .load(bus.valid_in),
    .a(bus.a_in[WD-1:WH]), .b(bus.x_in[WH-1:0]), .p(pp_hl)
  );
  relm_mul_half #(.WH(WH)) u_hh (
    .clk(clk), .rst_n(rst_n), .en(bus.en_in), .load(bus.valid_in),
    .a(bus.a_in[WD-1:WH]), .b(bus.x_in[WD-1:WH]), .p(pp_hh)
  );

`ifdef RELM_MUL_SIGNED_EN
  logic [WD:0] corr_d, corr_q;

  // Unsigned product minus 2^WD * corr yields the signed product mod 2^(2*WD).
  always_comb begin
    corr_d = '0;
    if (bus.signed_in && bus.a_in[WD-1]) corr_d = corr_d + {1'b0, bus.x_in};
    if (bus.signed_in && bus.x_in[WD-1]) corr_d = corr_d + {1'b0, bus.a_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_q <= '0;
    end else if (bus.en_in && bus.valid_in) begin
      corr_q <= corr_d;
    end
  end
`endif

  always_comb begin
    sum = {{WD{1'b0}}, pp_ll}
        + ({{WD{1'b0}}, pp_lh} << WH)
        + ({{WD{1'b0}}, pp_hl} << WH)
        + {pp_hh, {WD{1'b0}}};
`ifdef RELM_MUL_SIGNED_EN
    sum = sum - {corr_q[WD-1:0], {WD{1'b0}}};
`endif
  end

  // Flush clears the valid bits even while stalled; data registers only move when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (bus.en_in) begin
      v1_q <= bus.valid_in & ~bus.flush_in;
      v2_q <= v1_q & ~bus.flush_in;
    end else if (bus.flush_in) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax_q <= '0;
    end else if (bus.en_in && v1_q && !bus.flush_in) begin
      ax_q <= sum;
    end
  end

  always_comb begin
    bus.ax_out    = ax_q;
    bus.valid_out = v2_q;
    bus.busy_out  = v1_q | v2_q;
  end

endmodule

// File: tb/tb_relm_mul_pipe.sv
// Self-checking bench for relm_mul_pipe: directed corners plus randomized traffic
// against an operation-level reference model (RELM_MUL_SIGNED_EN aware).
module tb_relm_mul_pipe;
  import relm_mul_pipe_pkg::*;

  localparam int unsigned WD = RELM_WD;
  localparam int unsigned PW = 2 * WD;
  typedef logic [PW-1:0] prod_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  relm_mul_pipe_if #(.WD(WD)) bus ();

  relm_mul_pipe #(.WD(WD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  // Reference model: one in-flight slot per stage, products from plain arithmetic.
  bit    m_v1, m_v2;
  prod_t m_p1, m_ax;

  function automatic prod_t ref_prod(logic [WD-1:0] a, logic [WD-1:0] x, bit s);
    logic signed [PW-1:0] sa, sx;
    sa = {{WD{a[WD-1]}}, a};
    sx = {{WD{x[WD-1]}}, x};
    if (s) return prod_t'(sa * sx);
    return prod_t'({{WD{1'b0}}, a}) * prod_t'({{WD{1'b0}}, x});
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v1 = 1'b0;
      m_v2 = 1'b0;
      m_p1 = '0;
      m_ax = '0;
    end else if (bus.en_in) begin
      if (m_v1 && !bus.flush_in) m_ax = m_p1;
      m_v2 = m_v1 && !bus.flush_in;
      m_v1 = bus.valid_in && !bus.flush_in;
`ifdef RELM_MUL_SIGNED_EN
      if (bus.valid_in) m_p1 = ref_prod(bus.a_in, bus.x_in, bus.signed_in);
`else
      if (bus.valid_in) m_p1 = ref_prod(bus.a_in, bus.x_in, 1'b0);
`endif
    end else if (bus.flush_in) begin
      m_v1 = 1'b0;
      m_v2 = 1'b0;
    end
  end

  task automatic check(string name, prod_t got, prod_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(bit v, logic [WD-1:0] a, logic [WD-1:0] x,
                       bit s = 1'b0, bit en = 1'b1, bit fl = 1'b0);
    @(negedge clk);
    #1;
    bus.valid_in = v;
    bus.a_in     = a;
    bus.x_in     = x;
    bus.en_in    = en;
    bus.flush_in = fl;
`ifdef RELM_MUL_SIGNED_EN
    bus.signed_in = s;
`else
    if (s) $display("note: signed request ignored in unsigned build");
`endif
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic op_chk(string name, logic [WD-1:0] a, logic [WD-1:0] x, bit s, prod_t exp);
    drive(1'b1, a, x, s);
    drive(1'b0, '0, '0);
    after_edge();
    check(name, bus.ax_out, exp);
    check({name, "_valid"}, prod_t'(bus.valid_out), prod_t'(1'b1));
  endtask

  function automatic logic [WD-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(WD-1){1'b0}}};
      default: return WD'($urandom);
    endcase
  endfunction

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("model_valid_out", prod_t'(bus.valid_out), prod_t'(m_v2));
      check("model_busy_out", prod_t'(bus.busy_out), prod_t'(m_v1 | m_v2));
      check("model_ax_out", bus.ax_out, m_ax);
    end
  endtask

  task automatic stimulus();
    check("rst_ax", bus.ax_out, '0);
    check("rst_valid", prod_t'(bus.valid_out), '0);
    check("rst_busy", prod_t'(bus.busy_out), '0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    op_chk("uc_ones", '1, '1, 1'b0, 64'hFFFFFFFE00000001);
    op_chk("uc_half", 32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000);
    op_chk("uc_zero", 32'h0, 32'hDEADBEEF, 1'b0, 64'h0);

    // Back-to-back issue.
    drive(1'b1, 32'd2, 32'd3);
    drive(1'b1, 32'd4, 32'd5);
    after_edge();
    check("b2b_0", bus.ax_out, 64'd6);
    drive(1'b1, 32'd6, 32'd7);
    after_edge();
    check("b2b_1", bus.ax_out, 64'd20);
    check("b2b_1_valid", prod_t'(bus.valid_out), prod_t'(1'b1));
    drive(1'b0, '0, '0);
    after_edge();
    check("b2b_2", bus.ax_out, 64'd42);
    check("b2b_2_valid", prod_t'(bus.valid_out), prod_t'(1'b1));
    drive(1'b0, '0, '0);
    after_edge();
    check("b2b_idle_valid", prod_t'(bus.valid_out), '0);
    check("b2b_idle_busy", prod_t'(bus.busy_out), '0);

    // Stall four cycles after the first enabled edge.
    drive(1'b1, 32'd7, 32'd9);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      after_edge();
      check("stall_busy", prod_t'(bus.busy_out), prod_t'(1'b1));
      check("stall_ax", bus.ax_out, 64'd42);
    end
    drive(1'b0, '0, '0);
    after_edge();
    check("stall_result", bus.ax_out, 64'd63);
    check("stall_valid", prod_t'(bus.valid_out), prod_t'(1'b1));

    // Flush of an in-flight op, with and without a stall.
    drive(1'b1, 32'd11, 32'd13);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    after_edge();
    check("flush_valid", prod_t'(bus.valid_out), '0);
    check("flush_busy", prod_t'(bus.busy_out), '0);
    check("flush_ax", bus.ax_out, 64'd63);
    drive(1'b1, 32'd11, 32'd13);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    after_edge();
    check("flush_stall_busy", prod_t'(bus.busy_out), '0);
    drive(1'b1, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1);
    after_edge();
    check("flush_issue_busy", prod_t'(bus.busy_out), '0);
    drive(1'b0, '0, '0);
    after_edge();
    check("flush_late_valid", prod_t'(bus.valid_out), '0);
    check("flush_late_ax", bus.ax_out, 64'd63);

    // Asynchronous reset with an op in stage 1.
    drive(1'b1, 32'd3, 32'd5);
    after_edge();
    bus.valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ax", bus.ax_out, '0);
    check("midrst_valid", prod_t'(bus.valid_out), '0);
    check("midrst_busy", prod_t'(bus.busy_out), '0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0);
      after_edge();
      check("midrst_no_late", prod_t'(bus.valid_out), '0);
    end

`ifdef RELM_MUL_SIGNED_EN
    op_chk("s_ones", '1, '1, 1'b1, 64'h0000000000000001);
    op_chk("s_min2", 32'h80000000, 32'd2, 1'b1, 64'hFFFFFFFF00000000);
    op_chk("s_off_ones", '1, '1, 1'b0, 64'hFFFFFFFE00000001);
    op_chk("s_off_min2", 32'h80000000, 32'd2, 1'b0, 64'h0000000100000000);
`endif

    // Randomized traffic with stalls, flushes and one asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0);
    @(negedge clk);
  endtask

  initial begin
    bus.en_in    = 1'b1;
    bus.flush_in = 1'b0;
    bus.valid_in = 1'b0;
    bus.a_in     = '0;
    bus.x_in     = '0;
`ifdef RELM_MUL_SIGNED_EN
    bus.signed_in = 1'b0;
`endif
    #1;
    fork
      compare_loop();
      stimulus();
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
